game_control: RTL and testbench



---
 rtl/game_pkg.sv | 38 +++
 rtl/game_control_if.sv | 53 +++++
 rtl/game_control.sv | 148 ++++++++++++++
 tb/tb_game_control.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the maze-game controller and its datapath.
//   state_t          : controller state encoding (also exported for debug)
//   NONE..DOWN       : decoded key / move codes
//   SEL_INIT/INC/DEC : position-register select codes
//   is_move()        : true for the four direction codes; anything else is "none"
package game_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INIT  = 4'd1,
        S_DRAW0 = 4'd2,
        S_KEY   = 4'd3,
        S_DEC   = 4'd4,
        S_OBS   = 4'd5,
        S_WAIT  = 4'd6,
        S_CHK   = 4'd7,
        S_ERASE = 4'd8,
        S_STEP  = 4'd9,
        S_DRAW  = 4'd10,
        S_HOLD  = 4'd11,
        S_OVER  = 4'd12
    } state_t;

    localparam logic [2:0] NONE  = 3'd0;
    localparam logic [2:0] LEFT  = 3'd1;
    localparam logic [2:0] RIGHT = 3'd2;
    localparam logic [2:0] UP    = 3'd3;
    localparam logic [2:0] DOWN  = 3'd4;

    localparam logic [1:0] SEL_INIT = 2'd0;
    localparam logic [1:0] SEL_INC  = 2'd1;
    localparam logic [1:0] SEL_DEC  = 2'd2;

    function automatic logic is_move(input logic [2:0] m);
        return (m == LEFT) || (m == RIGHT) || (m == UP) || (m == DOWN);
    endfunction

endpackage

// File: rtl/game_control_if.sv
// Signal bundle between the game controller and its datapath.
//   Datapath -> controller : start, move, obs_block, timer_done, at_goal
//   Controller -> datapath : position/key/obstacle/timer enables and selects,
//                            VGA plot strobe and colour selects, busy, game_over
//   state                  : current controller state, for debug and checkers
// All signals are single-cycle levels sampled on the rising clock edge; there
// is no valid/ready handshake -- the controller owns the sequencing and the
// datapath simply obeys the enables it sees in each cycle.
interface game_control_if;
    import game_pkg::*;

    logic       start;
    logic [2:0] move;
    logic       obs_block;
    logic       timer_done;
    logic       at_goal;

    logic       en_xpos;
    logic       en_ypos;
    logic [1:0] s_xpos;
    logic [1:0] s_ypos;
    logic       en_key;
    logic       s_key;
    logic       en_obs;
    logic [2:0] s_obs;
    logic       plot;
    logic       s_color;
    logic       trail;
    logic       en_timer;
    logic       s_timer;
    logic       en_t;
    logic       s_t;
    logic       busy;
    logic       game_over;
    state_t     state;

    // Datapath side.
    modport master (
        output start, move, obs_block, timer_done, at_goal,
        input  en_xpos, en_ypos, s_xpos, s_ypos, en_key, s_key, en_obs, s_obs,
               plot, s_color, trail, en_timer, s_timer, en_t, s_t, busy,
               game_over, state
    );

    // Controller side.
    modport slave (
        input  start, move, obs_block, timer_done, at_goal,
        output en_xpos, en_ypos, s_xpos, s_ypos, en_key, s_key, en_obs, s_obs,
               plot, s_color, trail, en_timer, s_timer, en_t, s_t, busy,
               game_over, state
    );

endinterface

// File: rtl/game_control.sv
// Maze-game controller: Moore FSM that sequences key capture, obstacle lookup,
// erase/step/redraw of the player and the step-delay hold.
//   clk     : system clock, rising edge
//   resetn  : asynchronous active-low reset (forces S_IDLE, all outputs 0)
//   bus     : game_control_if.slave -- datapath inputs and control outputs
//   MEM_LAT : obstacle-memory read latency in cycles, 1..3
// An accepted key reaches S_STEP 4+MEM_LAT cycles after S_KEY:
// KEY, DEC, OBS(+WAITs), CHK, ERASE, STEP.
module game_control
    import game_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          resetn,
    game_control_if.slave bus
);

    // Last value of the latency counter before the memory data is valid.
    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [1:0] lat_q, lat_d;
    logic [2:0] move_q, move_d;

    always_comb begin : next_state
        state_d = state_q;
        lat_d   = lat_q;
        move_d  = move_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_INIT;
            S_INIT:  state_d = S_DRAW0;
            S_DRAW0: state_d = S_KEY;
            S_KEY:   state_d = S_DEC;
            S_DEC: begin
                if (is_move(bus.move)) begin
                    state_d = S_OBS;
                    lat_d   = 2'd0;
                    move_d  = bus.move;   // step direction used later in S_STEP
                end else begin
                    state_d = S_KEY;
                end
            end
            // S_OBS is the first cycle after the address load; S_WAIT pads
            // out the remaining memory latency.
            S_OBS, S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = S_CHK;
                    lat_d   = 2'd0;
                end else begin
                    state_d = S_WAIT;
                    lat_d   = lat_q + 2'd1;
                end
            end
            S_CHK:   state_d = bus.obs_block ? S_KEY : S_ERASE;
            S_ERASE: state_d = S_STEP;
            S_STEP:  state_d = S_DRAW;
            S_DRAW:  state_d = S_HOLD;
            S_HOLD: begin
                if (bus.at_goal)         state_d = S_OVER;
                else if (bus.timer_done) state_d = S_KEY;
            end
            S_OVER:  if (bus.start) state_d = S_INIT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            lat_q   <= 2'd0;
            move_q  <= NONE;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            move_q  <= move_d;
        end
    end

    always_comb begin : outputs
        bus.en_xpos   = 1'b0;
        bus.en_ypos   = 1'b0;
        bus.s_xpos    = SEL_INIT;
        bus.s_ypos    = SEL_INIT;
        bus.en_key    = 1'b0;
        bus.s_key     = 1'b0;
        bus.en_obs    = 1'b0;
        bus.s_obs     = NONE;
        bus.plot      = 1'b0;
        bus.s_color   = 1'b0;
        bus.trail     = 1'b0;
        bus.en_timer  = 1'b0;
        bus.s_timer   = 1'b0;
        bus.busy      = (state_q != S_IDLE) && (state_q != S_OVER);
        bus.game_over = (state_q == S_OVER);
        bus.state     = state_q;
        // Game clock runs in every in-game state after S_INIT cleared it.
        bus.en_t      = bus.busy;
        bus.s_t       = bus.busy && (state_q != S_INIT);

        unique case (state_q)
            S_INIT: begin
                bus.en_xpos  = 1'b1;
                bus.en_ypos  = 1'b1;
                bus.en_key   = 1'b1;
                bus.en_timer = 1'b1;
            end
            S_DRAW0: begin
                bus.plot    = 1'b1;
                bus.s_color = 1'b1;
            end
            S_KEY: begin
                bus.en_key = 1'b1;
                bus.s_key  = 1'b1;
            end
            S_DEC: begin
                if (is_move(bus.move)) begin
                    bus.en_obs = 1'b1;
                    bus.s_obs  = bus.move;
                end
            end
            S_ERASE: begin
                bus.plot  = 1'b1;
                bus.trail = 1'b1;
            end
            S_STEP: begin
                unique case (move_q)
                    LEFT:  begin bus.en_xpos = 1'b1; bus.s_xpos = SEL_DEC; end
                    RIGHT: begin bus.en_xpos = 1'b1; bus.s_xpos = SEL_INC; end
                    UP:    begin bus.en_ypos = 1'b1; bus.s_ypos = SEL_DEC; end
                    DOWN:  begin bus.en_ypos = 1'b1; bus.s_ypos = SEL_INC; end
                    default: ;
                endcase
            end
            S_DRAW: begin
                bus.plot    = 1'b1;
                bus.s_color = 1'b1;
            end
            S_HOLD: begin
                // Count while waiting; the cycle timer_done is seen restarts it.
                bus.en_timer = 1'b1;
                bus.s_timer  = ~bus.timer_done;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_game_control.sv
`timescale 1ns/1ps
module tb_game_control;
  import game_pkg::*;

  localparam int W = 21;

  typedef struct packed {
    logic       en_xpos;
    logic       en_ypos;
    logic [1:0] s_xpos;
    logic [1:0] s_ypos;
    logic       en_key;
    logic       s_key;
    logic       en_obs;
    logic [2:0] s_obs;
    logic       plot;
    logic       s_color;
    logic       trail;
    logic       en_timer;
    logic       s_timer;
    logic       en_t;
    logic       s_t;
    logic       busy;
    logic       game_over;
  } out_t;

  typedef struct packed {
    logic       start;
    logic [2:0] move;
    logic       obs_block;
    logic       timer_done;
    logic       at_goal;
  } in_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn1, resetn3;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  game_control_if if1();
  game_control_if if3();
  game_control #(.MEM_LAT(1)) dut1 (.clk(clk), .resetn(resetn1), .bus(if1));
  game_control #(.MEM_LAT(3)) dut3 (.clk(clk), .resetn(resetn3), .bus(if3));

  in_t cur_in;
  assign if1.start = cur_in.start;
  assign if1.move = cur_in.move;
  assign if1.obs_block = cur_in.obs_block;
  assign if1.timer_done = cur_in.timer_done;
  assign if1.at_goal = cur_in.at_goal;
  assign if3.start = cur_in.start;
  assign if3.move = cur_in.move;
  assign if3.obs_block = cur_in.obs_block;
  assign if3.timer_done = cur_in.timer_done;
  assign if3.at_goal = cur_in.at_goal;

  out_t o1, o3, cur_out;
  assign o1 = {if1.en_xpos, if1.en_ypos, if1.s_xpos, if1.s_ypos, if1.en_key, if1.s_key,
               if1.en_obs, if1.s_obs, if1.plot, if1.s_color, if1.trail, if1.en_timer,
               if1.s_timer, if1.en_t, if1.s_t, if1.busy, if1.game_over};
  assign o3 = {if3.en_xpos, if3.en_ypos, if3.s_xpos, if3.s_ypos, if3.en_key, if3.s_key,
               if3.en_obs, if3.s_obs, if3.plot, if3.s_color, if3.trail, if3.en_timer,
               if3.s_timer, if3.en_t, if3.s_t, if3.busy, if3.game_over};

  int lat = 1;   // latency of the DUT currently under test
  assign cur_out = (lat == 1) ? o1 : o3;
  state_t cur_st;
  assign cur_st = (lat == 1) ? if1.state : if3.state;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  in_t          in_q[$];
  string        tag_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input string tag, input in_t i, input out_t e);
    tag_q.push_back(tag);
    in_q.push_back(i);
    exp_q.push_back(e);
  endtask

  task automatic flush_q();
    tag_q.delete();
    in_q.delete();
    exp_q.delete();
  endtask

  // One entry per clock: drive inputs after the edge, compare mid-cycle.
  task automatic run_q(input string stop_tag);
    in_t i;
    logic [W-1:0] e;
    string t;
    while (in_q.size() > 0) begin
      i = in_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      @(posedge clk);
      #1;
      cur_in = i;
      #1;
      check(t, {11'b0, cur_out}, {11'b0, e});
      if (t == stop_tag) break;
    end
  endtask

  // ---------------- reference model (sequence generator) ----------------
  function automatic in_t rnd_in();
    in_t i;
    i.start      = 1'($urandom_range(0, 1));
    i.move       = 3'($urandom_range(0, 7));
    i.obs_block  = 1'($urandom_range(0, 1));
    i.timer_done = 1'($urandom_range(0, 1));
    i.at_goal    = 1'($urandom_range(0, 1));
    return i;
  endfunction

  // Outputs common to every in-game state after the first one.
  function automatic out_t in_game();
    out_t o = '0;
    o.busy = 1'b1;
    o.en_t = 1'b1;
    o.s_t  = 1'b1;
    return o;
  endfunction

  function automatic out_t parked(input logic over);
    out_t o = '0;
    o.game_over = over;
    return o;
  endfunction

  task automatic gen_idle(input int n, input logic over);
    in_t i;
    for (int k = 0; k < n; k++) begin
      i = rnd_in();
      i.start = 1'b0;
      push(over ? "over" : "idle", i, parked(over));
    end
  endtask

  task automatic gen_start(input logic from_over);
    in_t i;
    out_t e;
    i = rnd_in();
    i.start = 1'b1;
    push("start", i, parked(from_over));
    e = '0;
    e.busy = 1'b1; e.en_xpos = 1'b1; e.en_ypos = 1'b1;
    e.en_key = 1'b1; e.en_timer = 1'b1; e.en_t = 1'b1;
    push("init", rnd_in(), e);
    e = in_game();
    e.plot = 1'b1; e.s_color = 1'b1;
    push("draw0", rnd_in(), e);
  endtask

  // One pass from S_KEY: key capture, decode, lookup, and (if free) the move.
  task automatic gen_attempt(input logic [2:0] mv, input logic blocked, input int hold, input logic goal);
    in_t i;
    out_t e;
    logic valid;
    valid = (mv >= 3'd1) && (mv <= 3'd4);
    e = in_game(); e.en_key = 1'b1; e.s_key = 1'b1;
    push("key", rnd_in(), e);
    i = rnd_in(); i.move = mv;
    e = in_game();
    if (valid) begin e.en_obs = 1'b1; e.s_obs = mv; end
    push("dec", i, e);
    if (!valid) return;
    for (int k = 0; k < lat; k++) begin
      i = rnd_in(); i.obs_block = ~blocked;
      push("obs_wait", i, in_game());
    end
    i = rnd_in(); i.obs_block = blocked;
    push("chk", i, in_game());
    if (blocked) return;
    e = in_game(); e.plot = 1'b1; e.trail = 1'b1;
    push("erase", rnd_in(), e);
    e = in_game();
    case (mv)
      3'd1: begin e.en_xpos = 1'b1; e.s_xpos = 2'd2; end
      3'd2: begin e.en_xpos = 1'b1; e.s_xpos = 2'd1; end
      3'd3: begin e.en_ypos = 1'b1; e.s_ypos = 2'd2; end
      default: begin e.en_ypos = 1'b1; e.s_ypos = 2'd1; end
    endcase
    push("step", rnd_in(), e);
    e = in_game(); e.plot = 1'b1; e.s_color = 1'b1;
    push("draw", rnd_in(), e);
    if (goal) begin
      i = rnd_in(); i.at_goal = 1'b1; i.timer_done = 1'b0;
      e = in_game(); e.en_timer = 1'b1; e.s_timer = 1'b1;
      push("goal_hold", i, e);
      return;
    end
    for (int k = 0; k < hold - 1; k++) begin
      i = rnd_in(); i.at_goal = 1'b0; i.timer_done = 1'b0;
      e = in_game(); e.en_timer = 1'b1; e.s_timer = 1'b1;
      push("hold", i, e);
    end
    i = rnd_in(); i.at_goal = 1'b0; i.timer_done = 1'b1;
    e = in_game(); e.en_timer = 1'b1; e.s_timer = 1'b0;
    push("hold_clr", i, e);
  endtask

  task automatic random_attempts(input int n);
    for (int k = 0; k < n; k++) begin
      gen_attempt(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(1, 4), 1'b0);
      run_q("");
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cur_in  = '0;
    resetn1 = 1'b0;
    resetn3 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_lat1", {11'b0, o1}, 32'd0);
    check("rst_out_lat3", {11'b0, o3}, 32'd0);
    check("rst_state", {28'b0, if1.state}, {28'b0, S_IDLE});

    // MEM_LAT=1 DUT
    lat = 1;
    resetn1 = 1'b1;
    gen_idle(10, 1'b0);
    run_q("");
    check("idle_state", {28'b0, cur_st}, {28'b0, S_IDLE});

    gen_start(1'b0);
    gen_attempt(RIGHT, 1'b0, 3, 1'b0);   // free move right
    gen_attempt(UP, 1'b1, 1, 1'b0);      // blocked move up
    run_q("");
    random_attempts(15);
    gen_attempt(LEFT, 1'b0, 2, 1'b0);
    run_q("");

    // reset in the middle of a plot
    gen_attempt(RIGHT, 1'b0, 2, 1'b0);
    run_q("erase");
    flush_q();
    resetn1 = 1'b0;
    #1;
    check("rst_mid_plot", {11'b0, cur_out}, 32'd0);
    check("rst_mid_state", {28'b0, cur_st}, {28'b0, S_IDLE});
    @(posedge clk);
    #2;
    check("rst_hold_out", {11'b0, cur_out}, 32'd0);
    resetn1 = 1'b1;
    gen_idle(2, 1'b0);
    gen_start(1'b0);
    gen_attempt(DOWN, 1'b0, 1, 1'b0);
    gen_attempt(LEFT, 1'b0, 2, 1'b1);    // reaches goal
    gen_idle(3, 1'b1);
    gen_start(1'b1);                     // restart from S_OVER
    run_q("");
    check("restart_state", {28'b0, cur_st}, {28'b0, S_DRAW0});

    // MEM_LAT=3 DUT
    @(posedge clk);
    #1;
    resetn1 = 1'b0;
    resetn3 = 1'b1;
    lat = 3;
    gen_idle(3, 1'b0);
    gen_start(1'b0);
    gen_attempt(DOWN, 1'b0, 2, 1'b0);
    gen_attempt(3'd7, 1'b0, 1, 1'b0);    // illegal code: treated as none
    gen_attempt(RIGHT, 1'b1, 1, 1'b0);
    gen_attempt(UP, 1'b0, 1, 1'b0);
    run_q("");
    random_attempts(10);
    gen_attempt(RIGHT, 1'b0, 1, 1'b1);
    gen_idle(2, 1'b1);
    gen_start(1'b1);
    run_q("");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
